// File: rtl/bus_decoder.sv
// Registered address decoder and transfer tracker for the simple bus: maps power-of-two
// address windows to one-hot slave selects and ends misses and stalls with an error pulse.
module bus_decoder #(
  parameter int ADDR_W      = 8,
  parameter int N_SLAVE     = 2,
  parameter int REGION_BITS = 5,
  parameter int TIMEOUT     = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               m_req,
  input  logic [ADDR_W-1:0]  m_address,
  input  logic [N_SLAVE-1:0] slave_en,
  input  logic [N_SLAVE-1:0] s_ack,
  output logic [N_SLAVE-1:0] s_sel,
  output logic               m_ack,
  output logic               m_err,
  output logic [ADDR_W-1:0]  err_addr,
  output logic               busy
);

  localparam int IDX_W = ADDR_W - REGION_BITS;
  localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [CNT_W-1:0]   cnt_r;

  logic [IDX_W-1:0]   idx_s;
  logic [N_SLAVE-1:0] dec_s;
  logic               hit_s;
  logic               sel_ack_s;
  logic               accept_s;

  // Window decode of the live address plus acceptance and selected-ack qualifiers.
  always_comb begin
    idx_s = m_address[ADDR_W-1:REGION_BITS];
    dec_s = {N_SLAVE{1'b0}};
    for (int i = 0; i < N_SLAVE; i++) begin
      if (idx_s == IDX_W'(i)) begin
        dec_s[i] = 1'b1;
      end else begin
        dec_s[i] = 1'b0;
      end
    end
    hit_s     = |(dec_s & slave_en);
    sel_ack_s = |(s_sel & s_ack);
    // Gating on the registered pulses leaves one dead cycle so a held m_req is not relaunched.
    accept_s  = m_req & ~m_ack & ~m_err;
  end

  // Transfer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      s_sel    <= {N_SLAVE{1'b0}};
      m_ack    <= 1'b0;
      m_err    <= 1'b0;
      err_addr <= {ADDR_W{1'b0}};
      addr_r   <= {ADDR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      busy     <= 1'b0;
    end else begin
      m_ack <= 1'b0;
      m_err <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s && hit_s) begin
            s_sel   <= dec_s;
            addr_r  <= m_address;
            cnt_r   <= {CNT_W{1'b0}};
            busy    <= 1'b1;
            state_r <= ACTIVE;
          end else if (accept_s) begin
            m_err    <= 1'b1;
            err_addr <= m_address;
          end
        end
        ACTIVE: begin
          if (sel_ack_s) begin
            s_sel   <= {N_SLAVE{1'b0}};
            m_ack   <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else if ((TIMEOUT != 0) && (cnt_r == CNT_LAST)) begin
            s_sel    <= {N_SLAVE{1'b0}};
            m_err    <= 1'b1;
            err_addr <= addr_r;
            busy     <= 1'b0;
            state_r  <= IDLE;
          end else if (cnt_r != {CNT_W{1'b1}}) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          s_sel   <= {N_SLAVE{1'b0}};
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_decoder.sv
// Self-checking bench for bus_decoder: directed scenarios plus random traffic, every cycle
// compared against a transaction-level reference model.
module tb_bus_decoder;

  localparam int ADDR_W      = 8;
  localparam int N_SLAVE     = 2;
  localparam int REGION_BITS = 5;
  localparam int TIMEOUT     = 15;

  logic               clk = 1'b0;
  logic               reset;
  logic               m_req;
  logic [ADDR_W-1:0]  m_address;
  logic [N_SLAVE-1:0] slave_en;
  logic [N_SLAVE-1:0] s_ack;
  logic [N_SLAVE-1:0] s_sel;
  logic               m_ack;
  logic               m_err;
  logic [ADDR_W-1:0]  err_addr;
  logic               busy;

  int checks = 0;
  int errors = 0;

  // Reference model: a transfer in flight, which slave, and how many select cycles so far.
  bit                mdl_active;
  int                mdl_idx;
  int                mdl_age;
  logic              mdl_ack;
  logic              mdl_err;
  logic [ADDR_W-1:0] mdl_erra;
  logic [ADDR_W-1:0] mdl_lat;

  bus_decoder #(
    .ADDR_W(ADDR_W), .N_SLAVE(N_SLAVE), .REGION_BITS(REGION_BITS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_address(m_address), .slave_en(slave_en),
    .s_ack(s_ack), .s_sel(s_sel), .m_ack(m_ack), .m_err(m_err), .err_addr(err_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit launch;
    int idx;
    if (reset) begin
      mdl_active = 1'b0;
      mdl_ack    = 1'b0;
      mdl_err    = 1'b0;
      mdl_erra   = '0;
      mdl_age    = 0;
    end else if (mdl_active) begin
      mdl_ack = 1'b0;
      mdl_err = 1'b0;
      if (s_ack[mdl_idx]) begin
        mdl_active = 1'b0;
        mdl_ack    = 1'b1;
      end else if (TIMEOUT != 0 && mdl_age == TIMEOUT) begin
        mdl_active = 1'b0;
        mdl_err    = 1'b1;
        mdl_erra   = mdl_lat;
      end else begin
        mdl_age++;
      end
    end else begin
      launch  = m_req && !mdl_ack && !mdl_err;
      mdl_ack = 1'b0;
      mdl_err = 1'b0;
      if (launch) begin
        idx = int'(m_address) / (1 << REGION_BITS);
        if (idx < N_SLAVE && slave_en[idx]) begin
          mdl_active = 1'b1;
          mdl_idx    = idx;
          mdl_age    = 1;
          mdl_lat    = m_address;
        end else begin
          mdl_err  = 1'b1;
          mdl_erra = m_address;
        end
      end
    end
  endtask

  // Apply one cycle of inputs, clock it, then compare every output with the model.
  task automatic step(input logic rq, input logic [ADDR_W-1:0] ad, input logic [N_SLAVE-1:0] en,
                      input logic [N_SLAVE-1:0] ak, input logic rs);
    logic [31:0] exp_sel;
    m_req     = rq;
    m_address = ad;
    slave_en  = en;
    s_ack     = ak;
    reset     = rs;
    model_edge();
    @(posedge clk);
    #1;
    exp_sel = mdl_active ? (32'd1 << mdl_idx) : 32'd0;
    check_val("s_sel", 32'(s_sel), exp_sel);
    check_val("m_ack", 32'(m_ack), 32'(mdl_ack));
    check_val("m_err", 32'(m_err), 32'(mdl_err));
    check_val("err_addr", 32'(err_addr), 32'(mdl_erra));
    check_val("busy", 32'(busy), 32'(mdl_active));
  endtask

  initial begin
    reset = 1'b1; m_req = 1'b0; m_address = 8'h00; slave_en = 2'b00; s_ack = 2'b00;
    mdl_active = 1'b0; mdl_idx = 0; mdl_age = 0;
    mdl_ack = 1'b0; mdl_err = 1'b0; mdl_erra = 8'h00; mdl_lat = 8'h00;

    step(1'b0, 8'h00, 2'b00, 2'b00, 1'b1);
    step(1'b1, 8'h05, 2'b11, 2'b11, 1'b1);
    check_val("rst_sel", 32'(s_sel), 32'd0);

    // Slave 0 acks in its third select cycle.
    step(1'b1, 8'h05, 2'b11, 2'b00, 1'b0);
    check_val("t1_sel", 32'(s_sel), 32'd1);
    step(1'b1, 8'h05, 2'b11, 2'b00, 1'b0);
    step(1'b1, 8'h05, 2'b11, 2'b00, 1'b0);
    step(1'b0, 8'h05, 2'b11, 2'b01, 1'b0);
    check_val("t1_ack", 32'(m_ack), 32'd1);
    step(1'b0, 8'h00, 2'b11, 2'b00, 1'b0);

    // Address change and foreign ack mid-transfer are ignored.
    step(1'b1, 8'h2A, 2'b11, 2'b00, 1'b0);
    step(1'b1, 8'h00, 2'b11, 2'b01, 1'b0);
    check_val("t2_hold", 32'(s_sel), 32'd2);
    step(1'b0, 8'h00, 2'b11, 2'b00, 1'b0);
    step(1'b0, 8'h00, 2'b11, 2'b10, 1'b0);
    check_val("t2_ack", 32'(m_ack), 32'd1);
    step(1'b0, 8'h00, 2'b11, 2'b00, 1'b0);

    // Unmapped window, then disabled slave.
    step(1'b1, 8'h40, 2'b11, 2'b00, 1'b0);
    check_val("t3_err_addr0", 32'(err_addr), 32'h40);
    step(1'b0, 8'h40, 2'b11, 2'b00, 1'b0);
    step(1'b1, 8'h25, 2'b01, 2'b00, 1'b0);
    check_val("t3_err_addr1", 32'(err_addr), 32'h25);
    step(1'b0, 8'h25, 2'b01, 2'b00, 1'b0);

    // Timeout with no ack, then an ack landing in the final cycle.
    step(1'b1, 8'h10, 2'b11, 2'b00, 1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++) step(1'b0, 8'h10, 2'b11, 2'b00, 1'b0);
    check_val("t4_last_sel", 32'(s_sel), 32'd1);
    step(1'b0, 8'h10, 2'b11, 2'b00, 1'b0);
    check_val("t4_to_err", 32'(m_err), 32'd1);
    check_val("t4_to_addr", 32'(err_addr), 32'h10);
    step(1'b0, 8'h00, 2'b11, 2'b00, 1'b0);
    step(1'b1, 8'h11, 2'b11, 2'b00, 1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++) step(1'b0, 8'h11, 2'b11, 2'b00, 1'b0);
    step(1'b0, 8'h11, 2'b11, 2'b01, 1'b0);
    check_val("t4_late_ack", 32'(m_ack), 32'd1);
    check_val("t4_late_err", 32'(m_err), 32'd0);
    step(1'b0, 8'h00, 2'b11, 2'b00, 1'b0);

    // Held request across two acks: exactly one dead cycle in between.
    step(1'b1, 8'h30, 2'b11, 2'b00, 1'b0);
    step(1'b1, 8'h30, 2'b11, 2'b10, 1'b0);
    step(1'b1, 8'h30, 2'b11, 2'b00, 1'b0);
    check_val("t5_dead", 32'(s_sel), 32'd0);
    step(1'b1, 8'h30, 2'b11, 2'b00, 1'b0);
    check_val("t5_relaunch", 32'(s_sel), 32'd2);
    step(1'b1, 8'h30, 2'b11, 2'b10, 1'b0);
    step(1'b0, 8'h30, 2'b11, 2'b00, 1'b0);
    step(1'b0, 8'h30, 2'b11, 2'b00, 1'b0);

    // Reset during the second active cycle aborts the transfer.
    step(1'b1, 8'h05, 2'b11, 2'b00, 1'b0);
    step(1'b0, 8'h05, 2'b11, 2'b00, 1'b0);
    step(1'b0, 8'h05, 2'b11, 2'b00, 1'b1);
    check_val("t6_busy", 32'(busy), 32'd0);
    step(1'b0, 8'h05, 2'b11, 2'b01, 1'b0);
    check_val("t6_no_ack", 32'(m_ack), 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 3) != 0,
           ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 63)),
           2'($urandom_range(0, 3)),
           {($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0)},
           $urandom_range(0, 199) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
